// File: rtl/sentinel_attempt_ctrl.sv
// Attempt sequencer and brute-force throttle in front of the Sentinel key comparator.
// Optional build macro SENTINEL_BACKOFF_EN: each lockout doubles in length, up to 8x.
module sentinel_attempt_ctrl #(
    parameter logic [7:0] KEY            = 8'hB6,
    parameter int         MAX_FAILS      = 3,
    parameter int         LOCKOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] key_in,
    input  logic       submit,
    input  logic       relock,
    output logic       grant,
    output logic       reject,
    output logic       verified,
    output logic       lockout,
    output logic       fault,
    output logic [3:0] fail_cnt
);

    typedef enum logic [7:0] {
        S_IDLE    = 8'hA5,
        S_CHECK   = 8'h3C,
        S_GRANTED = 8'h5A,
        S_LOCKOUT = 8'hC3,
        S_FAULT   = 8'h00
    } state_e;

`ifdef SENTINEL_BACKOFF_EN
    localparam int TMR_W = 18;
`else
    localparam int TMR_W = 16;
`endif

    localparam logic [4:0] MAX_F = 5'(MAX_FAILS);

    // Plain vector rather than the enum type so any bit pattern, legal or not, can be held.
    (* keep = "true" *) logic [7:0] state_q;
    logic [7:0]       state_d;
    logic             submit_q;
    logic [7:0]       key_q, key_d;
    logic [3:0]       fail_q, fail_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             grant_q, grant_d;
    logic             reject_q, reject_d;
    logic             edge_det;
    logic             fail_last;

`ifdef SENTINEL_BACKOFF_EN
    logic [1:0] level_q, level_d;

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    function automatic logic [TMR_W-1:0] lock_load(input logic [1:0] lvl);
        return TMR_W'((int unsigned'(LOCKOUT_CYCLES) << lvl) - 32'd1);
    endfunction
`else
    function automatic logic [TMR_W-1:0] lock_load();
        return TMR_W'(LOCKOUT_CYCLES - 1);
    endfunction
`endif

    assign edge_det  = submit & ~submit_q;
    assign fail_last = ({1'b0, fail_q} + 5'd1) == MAX_F;

    always_comb begin
        state_d  = state_q;
        key_d    = key_q;
        fail_d   = fail_q;
        timer_d  = timer_q;
        grant_d  = 1'b0;
        reject_d = 1'b0;
`ifdef SENTINEL_BACKOFF_EN
        level_d  = level_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (edge_det) begin
                    key_d   = key_in;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (key_q == KEY) begin
                    state_d = S_GRANTED;
                    fail_d  = 4'd0;
                    grant_d = 1'b1;
`ifdef SENTINEL_BACKOFF_EN
                    level_d = 2'd0;
`endif
                end else if (fail_last) begin
                    // The failure that trips the lockout is signalled by lockout, not by reject.
                    state_d = S_LOCKOUT;
                    fail_d  = 4'd0;
`ifdef SENTINEL_BACKOFF_EN
                    timer_d = lock_load(level_q);
                    level_d = sat_inc2(level_q);
`else
                    timer_d = lock_load();
`endif
                end else begin
                    state_d  = S_IDLE;
                    fail_d   = fail_q + 4'd1;
                    reject_d = 1'b1;
                end
            end
            S_GRANTED: begin
                if (relock) begin
                    state_d = S_IDLE;
                end
            end
            S_LOCKOUT: begin
                if (timer_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            submit_q <= 1'b0;
            key_q    <= 8'h00;
            fail_q   <= 4'd0;
            timer_q  <= '0;
            grant_q  <= 1'b0;
            reject_q <= 1'b0;
`ifdef SENTINEL_BACKOFF_EN
            level_q  <= 2'd0;
`endif
        end else begin
            grant_q  <= ena & grant_d;
            reject_q <= ena & reject_d;
            if (ena) begin
                state_q  <= state_d;
                submit_q <= submit;
                key_q    <= key_d;
                fail_q   <= fail_d;
                timer_q  <= timer_d;
`ifdef SENTINEL_BACKOFF_EN
                level_q  <= level_d;
`endif
            end
        end
    end

    assign grant    = grant_q;
    assign reject   = reject_q;
    assign verified = (state_q == S_GRANTED);
    assign lockout  = (state_q == S_LOCKOUT);
    // Anything that is not one of the four working encodings reads as a fault.
    assign fault    = !((state_q == S_IDLE) || (state_q == S_CHECK) ||
                        (state_q == S_GRANTED) || (state_q == S_LOCKOUT));
    assign fail_cnt = fail_q;

endmodule

// File: tb/tb_sentinel_attempt_ctrl.sv
// Directed self-checking bench for sentinel_attempt_ctrl (default parameters).
module tb_sentinel_attempt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n, ena, submit, relock;
    logic [7:0] key_in;
    logic       grant, reject, verified, lockout, fault;
    logic [3:0] fail_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sentinel_attempt_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .key_in   (key_in),
        .submit   (submit),
        .relock   (relock),
        .grant    (grant),
        .reject   (reject),
        .verified (verified),
        .lockout  (lockout),
        .fault    (fault),
        .fail_cnt (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Rising submit edge with key k; returns after the compare result is visible.
    task automatic do_submit(input logic [7:0] k);
        key_in = k;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        tick();
    endtask

    // Called right after LOCKOUT entry is visible; counts enabled cycles spent in LOCKOUT.
    task automatic measure_lockout(output int n);
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (!lockout) break;
            n++;
        end
    endtask

    task automatic fail_into_lockout();
        for (int i = 0; i < 3; i++) do_submit(8'h00);
    endtask

    int  len;
    logic any_bad;

    initial begin
        rst_n = 1'b0; ena = 1'b1; submit = 1'b0; relock = 1'b0; key_in = 8'h00;
        tick(); tick();
        check("rst_grant", grant, 0);
        check("rst_reject", reject, 0);
        check("rst_verified", verified, 0);
        check("rst_lockout", lockout, 0);
        check("rst_fault", fault, 0);
        check("rst_fail_cnt", fail_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Correct key: grant two cycles after the edge.
        key_in = 8'hB6; submit = 1'b1;
        tick();
        check("grant_early", grant, 0);
        submit = 1'b0;
        tick();
        check("grant_pulse", grant, 1);
        check("grant_verified", verified, 1);
        check("grant_fail_cnt", fail_cnt, 0);
        tick();
        check("grant_one_cycle", grant, 0);
        check("verified_hold", verified, 1);

        // Relock together with an edge: relock wins, held edge not re-detected.
        relock = 1'b1; submit = 1'b1;
        tick();
        relock = 1'b0;
        check("relock_verified", verified, 0);
        tick(); tick();
        check("held_edge_grant", grant, 0);
        check("held_edge_reject", reject, 0);
        submit = 1'b0;
        tick();

        // Two rejects, then lockout with no reject.
        do_submit(8'h00);
        check("rej1_pulse", reject, 1);
        check("rej1_cnt", fail_cnt, 1);
        tick();
        check("rej1_one_cycle", reject, 0);
        do_submit(8'h00);
        check("rej2_pulse", reject, 1);
        check("rej2_cnt", fail_cnt, 2);
        do_submit(8'h00);
        check("lock_entry", lockout, 1);
        check("lock_no_reject", reject, 0);
        check("lock_cnt_clr", fail_cnt, 0);

        // Toggle submit with the correct key during LOCKOUT.
        len = 1; any_bad = 1'b0; key_in = 8'hB6;
        for (int i = 0; i < 100; i++) begin
            submit = ~submit;
            tick();
            if (grant || reject) any_bad = 1'b1;
            if (!lockout) break;
            len++;
        end
        check("lock_len", len, 16);
        check("lock_ignored_edges", any_bad, 0);
        submit = 1'b0;
        tick(); tick();
        check("post_lock_no_grant", grant, 0);
        do_submit(8'hB6);
        check("post_lock_grant", grant, 1);
        relock = 1'b1; tick(); relock = 1'b0;

        // One failure then success clears the count.
        do_submit(8'h11);
        check("partial_cnt", fail_cnt, 1);
        do_submit(8'hB6);
        check("partial_grant", grant, 1);
        check("partial_cnt_clr", fail_cnt, 0);
        relock = 1'b1; tick(); relock = 1'b0;

        // Freeze the timer with ena low mid-LOCKOUT.
        fail_into_lockout();
        check("frz_entry", lockout, 1);
        len = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (lockout) len++;
        end
        ena = 1'b0; any_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!lockout || grant || reject) any_bad = 1'b1;
        end
        check("frz_hold", any_bad, 0);
        ena = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!lockout) break;
            len++;
        end
        check("frz_lock_len", len, 16);
        tick();

        // Illegal encoding traps into FAULT.
        force dut.state_q = 8'hA4;
        #1;
        check("flt_fault", fault, 1);
        check("flt_verified", verified, 0);
        check("flt_lockout", lockout, 0);
        @(posedge clk);
        #1;
        release dut.state_q;
        tick();
        check("flt_trap", fault, 1);
        do_submit(8'hB6);
        check("flt_no_grant", grant, 0);
        check("flt_terminal", fault, 1);
        check("flt_no_verified", verified, 0);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("flt_rst_fault", fault, 0);
        check("flt_rst_cnt", fail_cnt, 0);
        tick();
        do_submit(8'hB6);
        check("flt_rst_grant", grant, 1);
        relock = 1'b1; tick(); relock = 1'b0;

        // Reset in the middle of LOCKOUT.
        fail_into_lockout();
        tick(); tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midlock_rst_lockout", lockout, 0);
        check("midlock_rst_cnt", fail_cnt, 0);
        tick();
        fail_into_lockout();
        measure_lockout(len);
        check("midlock_fresh_len", len, 16);
        tick();

`ifdef SENTINEL_BACKOFF_EN
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        fail_into_lockout();
        measure_lockout(len);
        check("bo_len0", len, 16);
        tick();
        fail_into_lockout();
        measure_lockout(len);
        check("bo_len1", len, 32);
        tick();
        fail_into_lockout();
        measure_lockout(len);
        check("bo_len2", len, 64);
        tick();
        do_submit(8'hB6);
        check("bo_grant", grant, 1);
        relock = 1'b1; tick(); relock = 1'b0;
        fail_into_lockout();
        measure_lockout(len);
        check("bo_len_clr", len, 16);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
